exec_pipe: RTL and testbench
============================

EXEC_PIPE -- requirements
Module: exec_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 16: operand and result width.
REQ-002 SHALL have parameter PC_W, default 14: npc and target width.
REQ-003 SHALL have parameter IMM_W, default 7: immediate width.
REQ-004 SHALL have parameter SHIFT_ITER, default 1: 1 means iterative 1-bit/cycle shifter; 0 means single-cycle barrel shifter.
REQ-005 SHALL have ports:
  clk  in  1  sole clock, rising edge.
  reset  in  1  synchronous active-high reset.
  flush  in  1  abort in-flight op, drop output.
  in_valid  in  1  op offered.
  in_ready  out  1  op accepted when in_valid&in_ready at clk edge.
  ctrl_in  in  5  [3:0] opcode, [4] passed through.
  dest_index_in  in  5  destination register index.
  reg1_data  in  DATA_W  operand A.
  reg2_data  in  DATA_W  operand B.
  npc  in  PC_W  next PC of the op.
  immediate  in  IMM_W  immediate field.
  out_valid  out  1  result held.
  out_ready  in  1  consumer takes result when out_valid&out_ready.
  ctrl_out  out  5  registered ctrl_in.
  dest_index_out  out  5  registered dest_index_in.
  result_out  out  DATA_W  ALU result/address.
  store_data_out  out  DATA_W  registered reg2_data.
  target  out  PC_W  branch target.
  branch_taken  out  1  jump resolved taken.
  dest_reg_write_en  out  1  result writes register file.
  zf, gf, lf  out  1 each  flag register.
  busy  out  1  iterative shift in progress.

Function
REQ-006 Opcodes SHALL be: 0 NOP, 1 SUB, 2 ADD, 3 ADDI, 4 SHLLI, 5 SHRLI, 6 JUMP, 7 JUMPL, 8 JUMPG, 9 JUMPE, A JUMPNE, B CMP, C LOAD, D LOADI, E STORE, F MOV.
REQ-007 result_out SHALL be: SUB A-B; ADD A+B; ADDI A+sext(imm); SHLLI A<<imm; SHRLI A>>imm (logical); LOAD/STORE A+sext(imm); LOADI zext(imm); MOV B; others 0; all mod 2^DATA_W.
REQ-008 Shift amount >= DATA_W SHALL yield 0.
REQ-009 target SHALL be npc+sext(imm) mod 2^PC_W for opcodes 6-A, else 0.
REQ-010 CMP SHALL load zf=(A==B), lf=(A<B unsigned), gf=(A>B unsigned) at acceptance edge; flags SHALL be unchanged by every other opcode and by flush.
REQ-011 branch_taken SHALL be JUMP 1; JUMPL lf; JUMPG gf; JUMPE zf; JUMPNE !zf; else 0; evaluated with flags as held before the branch's acceptance edge (a CMP accepted earlier, including the immediately preceding cycle, is visible).
REQ-012 dest_reg_write_en SHALL be 1 only for SUB, ADD, ADDI, SHLLI, SHRLI, LOAD, LOADI, MOV.
REQ-013 FSM states SHALL be IDLE, SHIFT, HOLD: IDLE->HOLD on accept of non-iterative op; IDLE->SHIFT on accept of SHLLI/SHRLI with SHIFT_ITER=1 and shamt>0; SHIFT->HOLD when remaining count reaches 0; HOLD->IDLE on out_ready without new accept, HOLD->HOLD on out_ready with simultaneous accept.
REQ-014 in_ready SHALL be 1 in IDLE, or in HOLD when out_ready=1; 0 in SHIFT.
REQ-015 Non-iterative op latency SHALL be 1 cycle: out_valid rises on the edge after acceptance.
REQ-016 Iterative shift SHALL take min(shamt,DATA_W)+1 cycles acceptance-to-out_valid; busy=1 exactly in SHIFT.
REQ-017 Outputs SHALL stay stable while out_valid=1 and out_ready=0.
REQ-018 flush SHALL force state IDLE, out_valid=0, busy=0 next edge, and SHALL block acceptance that cycle (in_ready=0 when flush=1).

Reset
REQ-019 reset SHALL have priority over flush and accept; next edge: state IDLE, out_valid=0, busy=0, zf=gf=lf=0, all data outputs, ctrl_out, dest_index_out, branch_taken, dest_reg_write_en = 0.
REQ-020 reset during SHIFT SHALL discard the shift without producing out_valid.

Verification
REQ-021 SUB A=10, B=3, out_ready=1 -> next cycle out_valid=1, result_out=7, dest_reg_write_en=1.
REQ-022 ADDI A=10, imm=7'h7F -> result_out=9 (sext -1).
REQ-023 SHLLI A=8, imm=3, SHIFT_ITER=1 -> busy 3 cycles, out_valid on 4th edge, result_out=64; imm=20 -> result_out=0.
REQ-024 CMP A=4, B=8 then JUMPL npc=5, imm=1 back-to-back -> lf=1, target=6, branch_taken=1; JUMPNE after CMP 7,7 -> branch_taken=0.
REQ-025 out_ready=0 for 3 cycles on LOADI imm=31 -> result_out=31 held, in_ready=0 until out_ready=1.
REQ-026 flush and reset mid-SHIFT -> out_valid never asserted, busy=0 next edge, flags retained on flush, cleared on reset.

Source files
------------

// File: rtl/exec_pipe.sv
// exec_pipe: single-issue execute stage. Decodes one op per accept, computes
// the ALU result, branch target and decision, and holds the outcome until the
// consumer takes it. Logical shifts either complete in the accept cycle or run
// on an iterative 1-bit-per-cycle shifter, depending on SHIFT_ITER.
//
// Handshake: an op transfers in on a clk edge where in_valid & in_ready. A
// result transfers out on a clk edge where out_valid & out_ready. Once
// out_valid is high, the outputs hold until that transfer happens.
module exec_pipe #(
  parameter int DATA_W     = 16,
  parameter int PC_W       = 14,
  parameter int IMM_W      = 7,
  parameter int SHIFT_ITER = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        ctrl_in,
  input  logic [4:0]        dest_index_in,
  input  logic [DATA_W-1:0] reg1_data,
  input  logic [DATA_W-1:0] reg2_data,
  input  logic [PC_W-1:0]   npc,
  input  logic [IMM_W-1:0]  immediate,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4:0]        ctrl_out,
  output logic [4:0]        dest_index_out,
  output logic [DATA_W-1:0] result_out,
  output logic [DATA_W-1:0] store_data_out,
  output logic [PC_W-1:0]   target,
  output logic              branch_taken,
  output logic              dest_reg_write_en,
  output logic              zf,
  output logic              gf,
  output logic              lf,
  output logic              busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;

  localparam logic [3:0] OP_SUB    = 4'h1;
  localparam logic [3:0] OP_ADD    = 4'h2;
  localparam logic [3:0] OP_ADDI   = 4'h3;
  localparam logic [3:0] OP_SHLLI  = 4'h4;
  localparam logic [3:0] OP_SHRLI  = 4'h5;
  localparam logic [3:0] OP_JUMP   = 4'h6;
  localparam logic [3:0] OP_JUMPL  = 4'h7;
  localparam logic [3:0] OP_JUMPG  = 4'h8;
  localparam logic [3:0] OP_JUMPE  = 4'h9;
  localparam logic [3:0] OP_JUMPNE = 4'hA;
  localparam logic [3:0] OP_CMP    = 4'hB;
  localparam logic [3:0] OP_LOAD   = 4'hC;
  localparam logic [3:0] OP_LOADI  = 4'hD;
  localparam logic [3:0] OP_STORE  = 4'hE;
  localparam logic [3:0] OP_MOV    = 4'hF;

  logic [1:0]        state;
  logic [DATA_W-1:0] shift_val;
  logic [DATA_W-1:0] shift_nxt;
  logic [CNT_W-1:0]  shift_cnt;
  logic              shift_left;

  logic [3:0]        op;
  logic [31:0]       shamt;
  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [PC_W-1:0]   pc_off;
  logic [DATA_W-1:0] alu_res;
  logic [PC_W-1:0]   target_d;
  logic              taken_d;
  logic              wen_d;
  logic              is_jump;
  logic              iter_d;
  logic [CNT_W-1:0]  iter_cnt;
  logic              accept;

  assign op       = ctrl_in[3:0];
  assign shamt    = 32'(immediate);
  assign imm_sext = DATA_W'($signed(immediate));
  assign imm_zext = DATA_W'(immediate);
  assign pc_off   = PC_W'($signed(immediate));

  // Flush blocks acceptance; SHIFT never accepts; HOLD accepts only when the
  // held result leaves on the same edge.
  assign in_ready  = !flush && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == HOLD);
  assign busy      = (state == SHIFT);

  assign is_jump  = (op >= OP_JUMP) && (op <= OP_JUMPNE);
  assign target_d = is_jump ? (npc + pc_off) : '0;

  // Shifts by a zero amount finish in one cycle like any other op.
  assign iter_d   = (SHIFT_ITER != 0) && ((op == OP_SHLLI) || (op == OP_SHRLI))
                    && (immediate != '0);
  assign iter_cnt = (shamt >= DATA_W) ? CNT_W'(DATA_W) : CNT_W'(shamt);

  assign shift_nxt = shift_left ? (shift_val << 1) : (shift_val >> 1);

  // Single-cycle ALU result for the op being offered.
  always_comb begin
    alu_res = '0;
    case (op)
      OP_SUB:                     alu_res = reg1_data - reg2_data;
      OP_ADD:                     alu_res = reg1_data + reg2_data;
      OP_ADDI, OP_LOAD, OP_STORE: alu_res = reg1_data + imm_sext;
      OP_SHLLI:                   alu_res = (shamt >= DATA_W) ? '0 : (reg1_data << shamt);
      OP_SHRLI:                   alu_res = (shamt >= DATA_W) ? '0 : (reg1_data >> shamt);
      OP_LOADI:                   alu_res = imm_zext;
      OP_MOV:                     alu_res = reg2_data;
      default:                    alu_res = '0;
    endcase
  end

  // Branch decision uses the flags as registered before this op's accept edge.
  always_comb begin
    taken_d = 1'b0;
    case (op)
      OP_JUMP:   taken_d = 1'b1;
      OP_JUMPL:  taken_d = lf;
      OP_JUMPG:  taken_d = gf;
      OP_JUMPE:  taken_d = zf;
      OP_JUMPNE: taken_d = !zf;
      default:   taken_d = 1'b0;
    endcase
  end

  // Register-file write enable for ops that produce a register value.
  always_comb begin
    wen_d = 1'b0;
    case (op)
      OP_SUB, OP_ADD, OP_ADDI, OP_SHLLI, OP_SHRLI,
      OP_LOAD, OP_LOADI, OP_MOV: wen_d = 1'b1;
      default:                   wen_d = 1'b0;
    endcase
  end

  // Control FSM, iterative shifter, output registers and flag register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      shift_val         <= '0;
      shift_cnt         <= '0;
      shift_left        <= 1'b0;
      ctrl_out          <= '0;
      dest_index_out    <= '0;
      result_out        <= '0;
      store_data_out    <= '0;
      target            <= '0;
      branch_taken      <= 1'b0;
      dest_reg_write_en <= 1'b0;
      zf                <= 1'b0;
      gf                <= 1'b0;
      lf                <= 1'b0;
    end else if (flush) begin
      state <= IDLE;
    end else if (accept) begin
      ctrl_out          <= ctrl_in;
      dest_index_out    <= dest_index_in;
      store_data_out    <= reg2_data;
      target            <= target_d;
      branch_taken      <= taken_d;
      dest_reg_write_en <= wen_d;
      if (op == OP_CMP) begin
        zf <= (reg1_data == reg2_data);
        lf <= (reg1_data < reg2_data);
        gf <= (reg1_data > reg2_data);
      end
      if (iter_d) begin
        state      <= SHIFT;
        shift_val  <= reg1_data;
        shift_cnt  <= iter_cnt;
        shift_left <= (op == OP_SHLLI);
      end else begin
        state      <= HOLD;
        result_out <= alu_res;
      end
    end else begin
      case (state)
        SHIFT: begin
          shift_val <= shift_nxt;
          shift_cnt <= shift_cnt - CNT_W'(1);
          if (shift_cnt == CNT_W'(1)) begin
            state      <= HOLD;
            result_out <= shift_nxt;
          end
        end
        HOLD: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exec_pipe.sv
// tb_exec_pipe: directed cases for the documented scenarios followed by a
// randomized run. Expected output vectors come from a behavioural model and
// are queued at issue time; a monitor pops them when a result transfers out.
module tb_exec_pipe;

  localparam int DW = 16;
  localparam int PW = 14;
  localparam int IW = 7;
  localparam int VW = 5 + 5 + DW + DW + PW + 1 + 1;

  logic          clk;
  logic          reset;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [4:0]    ctrl_in;
  logic [4:0]    dest_index_in;
  logic [DW-1:0] reg1_data;
  logic [DW-1:0] reg2_data;
  logic [PW-1:0] npc;
  logic [IW-1:0] immediate;
  logic          out_valid;
  logic          out_ready;
  logic [4:0]    ctrl_out;
  logic [4:0]    dest_index_out;
  logic [DW-1:0] result_out;
  logic [DW-1:0] store_data_out;
  logic [PW-1:0] target;
  logic          branch_taken;
  logic          dest_reg_write_en;
  logic          zf, gf, lf;
  logic          busy;

  exec_pipe #(.DATA_W(DW), .PC_W(PW), .IMM_W(IW), .SHIFT_ITER(1)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .ctrl_in(ctrl_in), .dest_index_in(dest_index_in),
    .reg1_data(reg1_data), .reg2_data(reg2_data),
    .npc(npc), .immediate(immediate),
    .out_valid(out_valid), .out_ready(out_ready),
    .ctrl_out(ctrl_out), .dest_index_out(dest_index_out),
    .result_out(result_out), .store_data_out(store_data_out),
    .target(target), .branch_taken(branch_taken),
    .dest_reg_write_en(dest_reg_write_en),
    .zf(zf), .gf(gf), .lf(lf), .busy(busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  // out_ready policy: 0 = low, 1 = high, 2 = random each cycle.
  int rdy_mode = 1;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [VW-1:0] exp_q[$];
  logic m_z = 1'b0, m_g = 1'b0, m_l = 1'b0;
  int acc_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model written from the opcode rules with integer arithmetic.
  function automatic logic [VW-1:0] model(input logic [4:0] ctrl, input logic [4:0] dest,
                                          input logic [DW-1:0] a, input logic [DW-1:0] b,
                                          input logic [PW-1:0] pc, input logic [IW-1:0] imm,
                                          input logic f_z, input logic f_g, input logic f_l);
    int simm, sh, op;
    logic [DW-1:0] r;
    logic [PW-1:0] t;
    logic tk, we;
    op   = int'(ctrl[3:0]);
    sh   = int'(imm);
    simm = (sh >= (1 << (IW - 1))) ? sh - (1 << IW) : sh;
    r = '0; t = '0; tk = 1'b0; we = 1'b0;
    case (op)
      1:          r = DW'(int'(a) - int'(b));
      2:          r = DW'(int'(a) + int'(b));
      3, 12, 14:  r = DW'(int'(a) + simm);
      4:          r = (sh >= DW) ? '0 : DW'(int'(a) * (1 << sh));
      5:          r = (sh >= DW) ? '0 : DW'(int'(a) / (1 << sh));
      13:         r = DW'(sh);
      15:         r = b;
      default:    r = '0;
    endcase
    if (op >= 6 && op <= 10) t = PW'(int'(pc) + simm);
    case (op)
      6:       tk = 1'b1;
      7:       tk = f_l;
      8:       tk = f_g;
      9:       tk = f_z;
      10:      tk = !f_z;
      default: tk = 1'b0;
    endcase
    we = (op inside {1, 2, 3, 4, 5, 12, 13, 15});
    return {ctrl, dest, r, b, t, tk, we};
  endfunction

  function automatic logic [VW-1:0] dut_vec();
    return {ctrl_out, dest_index_out, result_out, store_data_out, target,
            branch_taken, dest_reg_write_en};
  endfunction

  // ---------------- monitor ----------------
  bit held_pending = 0;
  logic [VW-1:0] held_vec, cur_vec, exp_vec;
  always @(negedge clk) begin
    if (reset) begin
      held_pending = 0;
    end else begin
      cur_vec = dut_vec();
      if (held_pending && out_valid) chk("hold_stable", 64'(cur_vec), 64'(held_vec));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 64'(1), 64'(0));
        end else begin
          exp_vec = exp_q.pop_front();
          chk("out_vec", 64'(cur_vec), 64'(exp_vec));
        end
      end
      held_pending = out_valid && !out_ready;
      held_vec     = cur_vec;
    end
  end

  // ---------------- driver tasks ----------------
  // Called 2 time units after a rising edge; returns 2 units after the accept edge.
  task automatic issue(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                       input logic [IW-1:0] imm, input logic [PW-1:0] pc,
                       input logic [4:0] dest, input logic c4, input bit push);
    bit ok;
    ctrl_in = {c4, op}; reg1_data = a; reg2_data = b; immediate = imm;
    npc = pc; dest_index_in = dest; in_valid = 1'b1;
    ok = 0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) begin
      chk("accept_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back(model({c4, op}, dest, a, b, pc, imm, m_z, m_g, m_l));
    if (op == 4'hB) begin
      m_z = (a == b); m_l = (a < b); m_g = (a > b);
    end
    @(posedge clk); #2;
    in_valid = 1'b0;
    acc_cyc  = cyc;
    chk("flag_zf", 64'(zf), 64'(m_z));
    chk("flag_gf", 64'(gf), 64'(m_g));
    chk("flag_lf", 64'(lf), 64'(m_l));
  endtask

  task automatic wait_out(input int exp_lat, input int exp_busy);
    int lat, nb;
    lat = -1; nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) begin lat = cyc - acc_cyc; break; end
      if (busy) nb++;
      @(posedge clk); #2;
    end
    chk("latency", 64'(lat), 64'(exp_lat));
    chk("busy_cycles", 64'(nb), 64'(exp_busy));
  endtask

  task automatic drain();
    bit done;
    done = 0;
    for (int k = 0; k < 400; k++) begin
      if (exp_q.size() == 0 && !out_valid) begin done = 1; break; end
      @(posedge clk); #2;
    end
    chk("drain", 64'(done), 64'(1));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit seen;
    logic [3:0]    r_op;
    logic [DW-1:0] r_a, r_b;
    logic [IW-1:0] r_imm;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; ctrl_in = '0; dest_index_in = '0;
    reg1_data = '0; reg2_data = '0; npc = '0; immediate = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_flags", 64'({zf, gf, lf}), 64'(0));
    chk("rst_vec", 64'(dut_vec()), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));

    // SUB 10-3
    issue(4'h1, 16'd10, 16'd3, 7'd0, 14'd0, 5'd3, 1'b0, 1);
    wait_out(0, 0);
    chk("sub_result", 64'(result_out), 64'(7));
    chk("sub_wen", 64'(dest_reg_write_en), 64'(1));

    // ADDI with immediate -1
    issue(4'h3, 16'd10, 16'd0, 7'h7F, 14'd0, 5'd4, 1'b1, 1);
    wait_out(0, 0);
    chk("addi_result", 64'(result_out), 64'(9));

    // Iterative shifts: short and saturated amounts
    issue(4'h4, 16'd8, 16'd0, 7'd3, 14'd0, 5'd5, 1'b0, 1);
    wait_out(3, 3);
    chk("shl3_result", 64'(result_out), 64'(64));
    issue(4'h4, 16'd8, 16'd0, 7'd20, 14'd0, 5'd5, 1'b0, 1);
    wait_out(16, 16);
    chk("shl20_result", 64'(result_out), 64'(0));
    issue(4'h5, 16'hF000, 16'd0, 7'd0, 14'd0, 5'd6, 1'b0, 1);
    wait_out(0, 0);

    // CMP then JUMPL back-to-back, then JUMPNE after equal compare
    issue(4'hB, 16'd4, 16'd8, 7'd0, 14'd0, 5'd0, 1'b0, 1);
    issue(4'h7, 16'd0, 16'd0, 7'd1, 14'd5, 5'd0, 1'b0, 1);
    wait_out(0, 0);
    chk("jumpl_target", 64'(target), 64'(6));
    chk("jumpl_taken", 64'(branch_taken), 64'(1));
    issue(4'hB, 16'd7, 16'd7, 7'd0, 14'd0, 5'd0, 1'b0, 1);
    issue(4'hA, 16'd0, 16'd0, 7'd2, 14'd9, 5'd0, 1'b0, 1);
    wait_out(0, 0);
    chk("jumpne_taken", 64'(branch_taken), 64'(0));
    drain();

    // Backpressure on LOADI
    rdy_mode = 0;
    @(posedge clk); #2;
    issue(4'hD, 16'd0, 16'd0, 7'd31, 14'd0, 5'd7, 1'b0, 1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_in_ready", 64'(in_ready), 64'(0));
      chk("bp_result", 64'(result_out), 64'(31));
      chk("bp_valid", 64'(out_valid), 64'(1));
      @(posedge clk); #2;
    end
    rdy_mode = 1;
    @(posedge clk); #2;
    chk("bp_in_ready_release", 64'(in_ready), 64'(1));
    drain();

    // Flush mid-shift: flags retained
    issue(4'hB, 16'd9, 16'd2, 7'd0, 14'd0, 5'd0, 1'b0, 1);
    drain();
    issue(4'h4, 16'd1, 16'd0, 7'd10, 14'd0, 5'd1, 1'b0, 0);
    @(posedge clk); #2;
    flush = 1'b1;
    @(posedge clk); #2;
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_valid", 64'(out_valid), 64'(0));
    chk("flush_flags", 64'({zf, gf, lf}), 64'({m_z, m_g, m_l}));
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #2;
    flush = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      seen |= out_valid;
      @(posedge clk); #2;
    end
    chk("flush_no_out", 64'(seen), 64'(0));

    // Reset mid-shift: flags cleared
    issue(4'hB, 16'd5, 16'd5, 7'd0, 14'd0, 5'd0, 1'b0, 1);
    drain();
    issue(4'h5, 16'hFFFF, 16'd0, 7'd12, 14'd0, 5'd2, 1'b0, 0);
    @(posedge clk); #2;
    reset = 1'b1;
    @(posedge clk); #2;
    reset = 1'b0;
    m_z = 1'b0; m_g = 1'b0; m_l = 1'b0;
    chk("rst2_busy", 64'(busy), 64'(0));
    chk("rst2_valid", 64'(out_valid), 64'(0));
    chk("rst2_flags", 64'({zf, gf, lf}), 64'(0));
    chk("rst2_vec", 64'(dut_vec()), 64'(0));
    seen = 0;
    for (int i = 0; i < 14; i++) begin
      seen |= out_valid;
      @(posedge clk); #2;
    end
    chk("rst2_no_out", 64'(seen), 64'(0));

    // Randomized run with random backpressure
    rdy_mode = 2;
    for (int n = 0; n < 300; n++) begin
      r_op  = 4'($urandom_range(0, 15));
      r_a   = DW'($urandom);
      r_b   = ($urandom_range(0, 3) == 0) ? r_a : DW'($urandom);
      r_imm = (r_op == 4'h4 || r_op == 4'h5) ? IW'($urandom_range(0, 20)) : IW'($urandom);
      issue(r_op, r_a, r_b, r_imm, PW'($urandom), 5'($urandom), 1'($urandom), 1);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #2;
      end
    end
    rdy_mode = 1;
    @(posedge clk); #2;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
